riffa_rx_port: RTL and testbench

Receive-side channel port of the PCIe DMA engine. Splits host scatter-gather (SG) buffer elements into PCIe read requests. Packs returned completion data into 128-bit words and buffers them in a FIFO. Presents one transaction to the user channel via a req/ack plus FIFO-style data interface. Single clock domain, between the TX/RX engines and the user channel.

---
 rtl/riffa_rx_pkg.sv | 18 +
 rtl/riffa_sync_fifo.sv | 61 ++++++
 rtl/riffa_rx_port.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_riffa_rx_port.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riffa_rx_pkg.sv
// Shared types and constants for the RIFFA receive port.
package riffa_rx_pkg;

    localparam int TAG_W           = 2;
    localparam int MAX_OUTSTANDING = 4;

    typedef enum logic [1:0] {RQ_IDLE, RQ_ARMED, RQ_ISSUE} rq_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_OFFER, TX_RUN} tx_state_e;

    // Max read request in 32-bit words for a PCIe size code, clamped to the legal range and a build cap.
    function automatic logic [10:0] size_code_words(input logic [2:0] code, input int cap);
        logic [2:0] c;
        c = (code > 3'd5) ? 3'd5 : code;
        if (int'(c) > cap) c = 3'(cap);
        return 11'd32 << c;
    endfunction

endpackage

// File: rtl/riffa_sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous clear; head word is zero while empty.
module riffa_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    always_comb begin
        do_rd    = rd_en && (count_q != '0);
        // A pop frees the slot this cycle, so a full FIFO still takes a push alongside it.
        do_wr    = wr_en && ((count_q != FULL_CNT) || do_rd) && !flush;
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_wr && !do_rd)      count_d = count_q + 1'b1;
        else if (do_rd && !do_wr) count_d = count_q - 1'b1;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/riffa_rx_port.sv
// RIFFA receive channel port: SG element -> read requests, completion packing, FIFO, channel handshake.
// Build option RX_PORT_4K_SPLIT_EN keeps every read request inside one 4KB address page.
module riffa_rx_port
    import riffa_rx_pkg::*;
#(
    parameter int C_DATA_WIDTH      = 128,
    parameter int C_MAIN_FIFO_DEPTH = 1024,
    parameter int C_MAX_READ_REQ    = 2
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [2:0]   CONFIG_MAX_READ_REQUEST_SIZE,
    input  logic [31:0]  PIO_DATA,
    input  logic         SG_BUF_ADDR_LO_VALID,
    input  logic         SG_BUF_ADDR_HI_VALID,
    input  logic         SG_BUF_LEN_VALID,
    output logic         SG_BUF_RECVD,
    input  logic         TXN_LEN_VALID,
    input  logic         TXN_OFF_LAST_VALID,
    output logic         TXN_DONE,
    output logic [31:0]  TXN_DONE_LEN,
    output logic         RX_REQ,
    input  logic         RX_REQ_ACK,
    output logic [1:0]   RX_REQ_TAG,
    output logic [63:0]  RX_REQ_ADDR,
    output logic [9:0]   RX_REQ_LEN,
    input  logic [127:0] MAIN_DATA,
    input  logic [2:0]   MAIN_DATA_EN,
    input  logic         MAIN_DONE,
    input  logic         MAIN_ERR,
    output logic         CHNL_RX,
    input  logic         CHNL_RX_ACK,
    output logic         CHNL_RX_LAST,
    output logic [31:0]  CHNL_RX_LEN,
    output logic [30:0]  CHNL_RX_OFF,
    output logic [127:0] CHNL_RX_DATA,
    output logic         CHNL_RX_DATA_VALID,
    input  logic         CHNL_RX_DATA_REN
);

    localparam int CW = $clog2(C_MAIN_FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FIFO_DEPTH_CNT = CW'(C_MAIN_FIFO_DEPTH);

    // Request engine state
    rq_state_e          rq_state_q, rq_state_d;
    logic [63:0]        addr_q, addr_d;
    logic [31:0]        rem_q, rem_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [2:0]         outst_q, outst_d;
    logic [31:0]        resv_q, resv_d;
    logic [10:0]        req_len_q, req_len_d;
    logic               recvd_q, recvd_d;
    logic [10:0]        max_words, size;
    logic [31:0]        free_words, resv_tmp;
    logic               space_ok, req_ack;
`ifdef RX_PORT_4K_SPLIT_EN
    logic [10:0]        bnd_words;
`endif

    // Transaction / packer state
    tx_state_e          tx_state_q, tx_state_d;
    logic [31:0]        txn_len_q, txn_len_d;
    logic [30:0]        off_q, off_d;
    logic               last_q, last_d;
    logic [31:0]        rcvd_q, rcvd_d;
    logic [31:0]        popped_q, popped_d, left;
    logic [3:0][31:0]   acc_q, acc_d;
    logic [1:0]         acc_cnt_q, acc_cnt_d;
    logic               done_q, done_d;
    logic [31:0]        done_len_q, done_len_d;
    logic [7:0][31:0]   combo;
    logic [2:0]         en_w, rx_words, n_words, pos;
    logic               flush_now, err_abort, pop, push;
    logic [C_DATA_WIDTH-1:0] push_data;

    logic               fifo_empty;
    logic [CW-1:0]      fifo_count, free_entries;

    always_comb begin
        rq_state_d = rq_state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        tag_d      = tag_q;
        req_len_d  = req_len_q;
        recvd_d    = 1'b0;
        req_ack    = 1'b0;
        max_words  = size_code_words(CONFIG_MAX_READ_REQUEST_SIZE, C_MAX_READ_REQ);
        size       = (rem_q < 32'(max_words)) ? rem_q[10:0] : max_words;
`ifdef RX_PORT_4K_SPLIT_EN
        bnd_words  = 11'd1024 - 11'(addr_q[11:2]);
        if (bnd_words < size) size = bnd_words;
`endif
        free_entries = FIFO_DEPTH_CNT - fifo_count;
        free_words   = 32'({free_entries, 2'b00});
        space_ok     = free_words >= resv_q + 32'(size);

        case (rq_state_q)
            RQ_IDLE: begin
                if (SG_BUF_ADDR_LO_VALID) addr_d[31:0]  = PIO_DATA;
                if (SG_BUF_ADDR_HI_VALID) addr_d[63:32] = PIO_DATA;
                if (SG_BUF_LEN_VALID) begin
                    rem_d = PIO_DATA;
                    if (PIO_DATA == '0) recvd_d    = 1'b1;
                    else                rq_state_d = RQ_ARMED;
                end
            end
            RQ_ARMED: begin
                if (outst_q < 3'(MAX_OUTSTANDING) && space_ok) begin
                    rq_state_d = RQ_ISSUE;
                    req_len_d  = size;
                end
            end
            RQ_ISSUE: begin
                if (RX_REQ_ACK) begin
                    req_ack = 1'b1;
                    addr_d  = addr_q + {51'd0, req_len_q, 2'b00};
                    rem_d   = rem_q - 32'(req_len_q);
                    tag_d   = tag_q + 1'b1;
                    if (rem_d == '0) begin
                        recvd_d    = 1'b1;
                        rq_state_d = RQ_IDLE;
                    end else begin
                        rq_state_d = RQ_ARMED;
                    end
                end
            end
            default: rq_state_d = RQ_IDLE;
        endcase

        outst_d = outst_q;
        if (req_ack && !MAIN_DONE)                     outst_d = outst_q + 1'b1;
        else if (!req_ack && MAIN_DONE && outst_q != 0) outst_d = outst_q - 1'b1;

        // Reserved words: requested but not yet landed in the packer.
        resv_tmp = resv_q + (req_ack ? 32'(req_len_q) : 32'd0);
        resv_d   = (resv_tmp > 32'(rx_words)) ? resv_tmp - 32'(rx_words) : 32'd0;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        txn_len_d  = txn_len_q;
        off_d      = off_q;
        last_d     = last_q;
        rcvd_d     = rcvd_q;
        popped_d   = popped_q;
        acc_d      = acc_q;
        acc_cnt_d  = acc_cnt_q;
        done_d     = 1'b0;
        done_len_d = done_len_q;
        push       = 1'b0;
        push_data  = '0;
        combo      = '0;
        pos        = '0;
        n_words    = '0;
        left       = '0;

        err_abort = MAIN_ERR && (tx_state_q != TX_IDLE);
        // Residue is drained one cycle after the final word arrives so only one push per cycle is needed.
        flush_now = (tx_state_q != TX_IDLE) && (acc_cnt_q != 2'd0) && (rcvd_q >= txn_len_q);
        en_w      = (MAIN_DATA_EN > 3'd4) ? 3'd4 : MAIN_DATA_EN;
        rx_words  = (flush_now || err_abort) ? 3'd0 : en_w;
        pop       = CHNL_RX_DATA_REN && !fifo_empty;

        if (flush_now) begin
            push      = 1'b1;
            push_data = acc_q;
            acc_d     = '0;
            acc_cnt_d = 2'd0;
        end else if (rx_words != 3'd0) begin
            combo[3:0] = acc_q;
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < rx_words) begin
                    pos        = {1'b0, acc_cnt_q} + 3'(k);
                    combo[pos] = MAIN_DATA[32*k +: 32];
                end
            end
            n_words = {1'b0, acc_cnt_q} + rx_words;
            if (n_words >= 3'd4) begin
                push      = 1'b1;
                push_data = combo[3:0];
                acc_d     = combo[7:4];
                acc_cnt_d = 2'(n_words - 3'd4);
            end else begin
                acc_d     = combo[3:0];
                acc_cnt_d = n_words[1:0];
            end
            rcvd_d = rcvd_q + 32'(rx_words);
        end

        if (tx_state_q == TX_RUN && pop) begin
            left     = txn_len_q - popped_q;
            popped_d = popped_q + ((left > 32'd4) ? 32'd4 : left);
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (TXN_LEN_VALID) txn_len_d = PIO_DATA;
                if (TXN_OFF_LAST_VALID) begin
                    off_d      = PIO_DATA[31:1];
                    last_d     = PIO_DATA[0];
                    tx_state_d = TX_OFFER;
                end
            end
            TX_OFFER: if (CHNL_RX_ACK) tx_state_d = TX_RUN;
            TX_RUN: begin
                if (popped_q >= txn_len_q) begin
                    done_d     = 1'b1;
                    done_len_d = popped_q;
                    tx_state_d = TX_IDLE;
                    rcvd_d     = '0;
                    popped_d   = '0;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // An error reports what has arrived so far and throws away everything buffered.
        if (err_abort) begin
            done_d     = 1'b1;
            done_len_d = rcvd_q;
            tx_state_d = TX_IDLE;
            rcvd_d     = '0;
            popped_d   = '0;
            acc_d      = '0;
            acc_cnt_d  = 2'd0;
            push       = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rq_state_q <= RQ_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            tag_q      <= '0;
            outst_q    <= '0;
            resv_q     <= '0;
            req_len_q  <= '0;
            recvd_q    <= 1'b0;
            tx_state_q <= TX_IDLE;
            txn_len_q  <= '0;
            off_q      <= '0;
            last_q     <= 1'b0;
            rcvd_q     <= '0;
            popped_q   <= '0;
            acc_q      <= '0;
            acc_cnt_q  <= '0;
            done_q     <= 1'b0;
            done_len_q <= '0;
        end else begin
            rq_state_q <= rq_state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            tag_q      <= tag_d;
            outst_q    <= outst_d;
            resv_q     <= resv_d;
            req_len_q  <= req_len_d;
            recvd_q    <= recvd_d;
            tx_state_q <= tx_state_d;
            txn_len_q  <= txn_len_d;
            off_q      <= off_d;
            last_q     <= last_d;
            rcvd_q     <= rcvd_d;
            popped_q   <= popped_d;
            acc_q      <= acc_d;
            acc_cnt_q  <= acc_cnt_d;
            done_q     <= done_d;
            done_len_q <= done_len_d;
        end
    end

    riffa_sync_fifo #(
        .WIDTH (C_DATA_WIDTH),
        .DEPTH (C_MAIN_FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .flush   (err_abort),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (CHNL_RX_DATA_REN),
        .rd_data (CHNL_RX_DATA),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign RX_REQ             = (rq_state_q == RQ_ISSUE);
    assign RX_REQ_ADDR        = addr_q;
    assign RX_REQ_LEN         = req_len_q[9:0];
    assign RX_REQ_TAG         = tag_q;
    assign SG_BUF_RECVD       = recvd_q;
    assign CHNL_RX            = (tx_state_q == TX_OFFER);
    assign CHNL_RX_LEN        = txn_len_q;
    assign CHNL_RX_OFF        = off_q;
    assign CHNL_RX_LAST       = last_q;
    assign CHNL_RX_DATA_VALID = !fifo_empty;
    assign TXN_DONE           = done_q;
    assign TXN_DONE_LEN       = done_len_q;

endmodule

// File: tb/tb_riffa_rx_port.sv
// Randomized bench for riffa_rx_port against a queue/arithmetic reference; honours RX_PORT_4K_SPLIT_EN.
module tb_riffa_rx_port;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [2:0]   CONFIG_MAX_READ_REQUEST_SIZE = '0;
    logic [31:0]  PIO_DATA = '0;
    logic         SG_BUF_ADDR_LO_VALID = 0, SG_BUF_ADDR_HI_VALID = 0, SG_BUF_LEN_VALID = 0;
    logic         TXN_LEN_VALID = 0, TXN_OFF_LAST_VALID = 0;
    logic         RX_REQ_ACK = 0, MAIN_DONE = 0, MAIN_ERR = 0, CHNL_RX_ACK = 0, CHNL_RX_DATA_REN = 0;
    logic [127:0] MAIN_DATA = '0;
    logic [2:0]   MAIN_DATA_EN = '0;
    logic         SG_BUF_RECVD, TXN_DONE, RX_REQ, CHNL_RX, CHNL_RX_LAST, CHNL_RX_DATA_VALID;
    logic [31:0]  TXN_DONE_LEN, CHNL_RX_LEN;
    logic [1:0]   RX_REQ_TAG;
    logic [63:0]  RX_REQ_ADDR;
    logic [9:0]   RX_REQ_LEN;
    logic [30:0]  CHNL_RX_OFF;
    logic [127:0] CHNL_RX_DATA;

    riffa_rx_port dut (
        .CLK(CLK), .RST_N(RST_N), .CONFIG_MAX_READ_REQUEST_SIZE(CONFIG_MAX_READ_REQUEST_SIZE),
        .PIO_DATA(PIO_DATA), .SG_BUF_ADDR_LO_VALID(SG_BUF_ADDR_LO_VALID),
        .SG_BUF_ADDR_HI_VALID(SG_BUF_ADDR_HI_VALID), .SG_BUF_LEN_VALID(SG_BUF_LEN_VALID),
        .SG_BUF_RECVD(SG_BUF_RECVD), .TXN_LEN_VALID(TXN_LEN_VALID),
        .TXN_OFF_LAST_VALID(TXN_OFF_LAST_VALID), .TXN_DONE(TXN_DONE), .TXN_DONE_LEN(TXN_DONE_LEN),
        .RX_REQ(RX_REQ), .RX_REQ_ACK(RX_REQ_ACK), .RX_REQ_TAG(RX_REQ_TAG),
        .RX_REQ_ADDR(RX_REQ_ADDR), .RX_REQ_LEN(RX_REQ_LEN), .MAIN_DATA(MAIN_DATA),
        .MAIN_DATA_EN(MAIN_DATA_EN), .MAIN_DONE(MAIN_DONE), .MAIN_ERR(MAIN_ERR),
        .CHNL_RX(CHNL_RX), .CHNL_RX_ACK(CHNL_RX_ACK), .CHNL_RX_LAST(CHNL_RX_LAST),
        .CHNL_RX_LEN(CHNL_RX_LEN), .CHNL_RX_OFF(CHNL_RX_OFF), .CHNL_RX_DATA(CHNL_RX_DATA),
        .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID), .CHNL_RX_DATA_REN(CHNL_RX_DATA_REN)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_pass = 0;
    int recvd_cnt = 0, done_cnt = 0;
    logic [31:0] done_len_seen = '0;
    logic [1:0]  exp_tag = '0;

    always @(negedge CLK) begin
        if (SG_BUF_RECVD) recvd_cnt++;
        if (TXN_DONE) begin
            done_cnt++;
            done_len_seen = TXN_DONE_LEN;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic do_reset();
        RST_N = 0;
        {SG_BUF_ADDR_LO_VALID, SG_BUF_ADDR_HI_VALID, SG_BUF_LEN_VALID, TXN_LEN_VALID, TXN_OFF_LAST_VALID} = '0;
        {RX_REQ_ACK, MAIN_DONE, MAIN_ERR, CHNL_RX_ACK, CHNL_RX_DATA_REN} = '0;
        MAIN_DATA_EN = '0;
        MAIN_DATA = '0;
        tick();
        tick();
        RST_N = 1;
        exp_tag = '0;
    endtask

    // sel: 0 addr lo, 1 addr hi, 2 sg len, 3 txn len, 4 txn off/last
    task automatic pio_wr(input int sel, input logic [31:0] d);
        PIO_DATA = d;
        SG_BUF_ADDR_LO_VALID = (sel == 0);
        SG_BUF_ADDR_HI_VALID = (sel == 1);
        SG_BUF_LEN_VALID     = (sel == 2);
        TXN_LEN_VALID        = (sel == 3);
        TXN_OFF_LAST_VALID   = (sel == 4);
        tick();
        {SG_BUF_ADDR_LO_VALID, SG_BUF_ADDR_HI_VALID, SG_BUF_LEN_VALID, TXN_LEN_VALID, TXN_OFF_LAST_VALID} = '0;
    endtask

    task automatic wait_req(output bit ok);
        for (int i = 0; i < 200 && !RX_REQ; i++) tick();
        ok = RX_REQ;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        for (int i = 0; i < 40 && done_cnt <= d0; i++) tick();
        ok = (done_cnt > d0);
    endtask

    // Model: each request = min(remaining, 32 << min(cfg,2)), optionally clipped at the next 4KB page.
    task automatic run_elem(input logic [2:0] cfg, input logic [63:0] addr, input int len, input bit send_done);
        logic [63:0] a;
        int rem, sz, r0, cap;
        bit ok;
        CONFIG_MAX_READ_REQUEST_SIZE = cfg;
        r0 = recvd_cnt;
        a = addr;
        rem = len;
        pio_wr(0, addr[31:0]);
        pio_wr(1, addr[63:32]);
        pio_wr(2, len);
        while (rem > 0) begin
            cap = 32 << imin(int'(cfg), 2);
            sz = imin(rem, cap);
`ifdef RX_PORT_4K_SPLIT_EN
            sz = imin(sz, int'((64'd4096 - (a % 64'd4096)) / 64'd4));
`endif
            wait_req(ok);
            chk("req_seen", ok, 1'b1);
            if (!ok) return;
            repeat ($urandom_range(0, 2)) tick();
            chk("req_addr", RX_REQ_ADDR, a);
            chk("req_len", RX_REQ_LEN, sz[9:0]);
            chk("req_tag", RX_REQ_TAG, exp_tag);
            RX_REQ_ACK = 1;
            tick();
            RX_REQ_ACK = 0;
            MAIN_DONE = send_done;
            tick();
            MAIN_DONE = 0;
            a = a + 64'(4 * sz);
            rem = rem - sz;
            exp_tag = exp_tag + 2'd1;
        end
        repeat (3) tick();
        chk("sg_recvd_once", recvd_cnt - r0, 1);
    endtask

    task automatic start_txn(input int len, output logic [31:0] off);
        off = $urandom;
        pio_wr(3, len);
        pio_wr(4, off);
        chk("chnl_rx_up", CHNL_RX, 1'b1);
        chk("chnl_rx_off", CHNL_RX_OFF, off[31:1]);
        chk("chnl_rx_last", CHNL_RX_LAST, off[0]);
        chk("chnl_rx_len", CHNL_RX_LEN, len);
        pio_wr(4, ~off);
        chk("txn_rewrite_ignored", CHNL_RX_OFF, off[31:1]);
        CHNL_RX_ACK = 1;
        tick();
        CHNL_RX_ACK = 0;
        chk("chnl_rx_dropped", CHNL_RX, 1'b0);
    endtask

    // Send exactly n words in beats; directed beats follow 3,2,3.
    task automatic feed(input int n, input bit directed, inout logic [31:0] q[$]);
        int sent, en, idx;
        int dseq [3];
        logic [127:0] d;
        dseq = '{3, 2, 3};
        sent = 0;
        idx = 0;
        while (sent < n) begin
            en = (directed && idx < 3) ? dseq[idx] : $urandom_range(0, imin(4, n - sent));
            idx++;
            d = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < en; k++) q.push_back(d[32*k +: 32]);
            MAIN_DATA = d;
            MAIN_DATA_EN = 3'(en);
            tick();
            sent += en;
        end
        MAIN_DATA_EN = '0;
        MAIN_DATA = '0;
    endtask

    task automatic run_pack(input int len, input bit directed);
        logic [31:0] q[$];
        logic [31:0] off;
        logic [127:0] exp;
        int d0, cyc;
        bit ok;
        d0 = done_cnt;
        start_txn(len, off);
        feed(len, directed, q);
        for (int j = 0; j < (len + 3) / 4; j++) begin
            for (cyc = 0; cyc < 20 && !CHNL_RX_DATA_VALID; cyc++) tick();
            chk("fifo_valid", CHNL_RX_DATA_VALID, 1'b1);
            exp = '0;
            for (int k = 0; k < 4; k++) if (q.size() > 0) exp[32*k +: 32] = q.pop_front();
            chk("fifo_data", CHNL_RX_DATA, exp);
            CHNL_RX_DATA_REN = 1;
            tick();
            CHNL_RX_DATA_REN = 0;
        end
        chk("fifo_drained", CHNL_RX_DATA_VALID, 1'b0);
        wait_done(d0, ok);
        chk("txn_done", ok, 1'b1);
        chk("txn_done_once", done_cnt - d0, 1);
        chk("txn_done_len", done_len_seen, len);
    endtask

    task automatic run_err(input int len, input int k);
        logic [31:0] q[$];
        logic [31:0] off;
        int d0;
        bit ok;
        d0 = done_cnt;
        start_txn(len, off);
        feed(k, 1'b0, q);
        MAIN_ERR = 1;
        tick();
        MAIN_ERR = 0;
        wait_done(d0, ok);
        chk("err_done", ok, 1'b1);
        chk("err_done_len", done_len_seen, k);
        tick();
        chk("err_fifo_flushed", CHNL_RX_DATA_VALID, 1'b0);
    endtask

    initial begin
        bit ok, stall;
        int d0;
        logic [31:0] off;

        // Reset: every output low
        do_reset();
        RST_N = 0;
        tick();
        tick();
        chk("reset_outputs",
            {SG_BUF_RECVD, TXN_DONE, TXN_DONE_LEN, RX_REQ, RX_REQ_TAG, RX_REQ_ADDR, RX_REQ_LEN,
             CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA_VALID}, '0);
        chk("reset_data", CHNL_RX_DATA, '0);
        RST_N = 1;

        // Directed split: 300 words at 0x1000, CONFIG=2
        do_reset();
        run_elem(3'd2, 64'h1000, 300, 1'b0);

        // Randomized elements
        for (int i = 0; i < 10; i++) begin
            do_reset();
            run_elem(3'($urandom_range(0, 7)), {$urandom, $urandom} & ~64'h3,
                     $urandom_range(1, 600), 1'b1);
        end

        // Cap and outstanding limit
        do_reset();
        CONFIG_MAX_READ_REQUEST_SIZE = 3'd5;
        pio_wr(0, 32'h0);
        pio_wr(1, 32'h0);
        pio_wr(2, 32'd1000);
        for (int i = 0; i < 4; i++) begin
            wait_req(ok);
            chk("cap_req_seen", ok, 1'b1);
            chk("cap_len", RX_REQ_LEN, 10'd128);
            RX_REQ_ACK = 1;
            tick();
            RX_REQ_ACK = 0;
        end
        stall = 0;
        repeat (20) begin
            tick();
            if (RX_REQ) stall = 1;
        end
        chk("cap_fifth_withheld", stall, 1'b0);
        MAIN_DONE = 1;
        tick();
        MAIN_DONE = 0;
        wait_req(ok);
        chk("cap_resume", ok, 1'b1);
        chk("cap_resume_len", RX_REQ_LEN, 10'd128);

`ifdef RX_PORT_4K_SPLIT_EN
        do_reset();
        run_elem(3'd2, 64'h0FF0, 64, 1'b1);
`endif

        // Packing: directed 3,2,3 into 8 words, then random lengths
        do_reset();
        run_pack(8, 1'b1);
        for (int i = 0; i < 8; i++) run_pack($urandom_range(1, 40), 1'b0);

        // Error abort: directed 5 words, then random partial counts
        run_err(20, 5);
        for (int i = 0; i < 4; i++) run_err(40, $urandom_range(1, 39));

        // Zero-length transaction finishes right after the ack
        d0 = done_cnt;
        start_txn(0, off);
        wait_done(d0, ok);
        chk("zero_len_done", ok, 1'b1);
        chk("zero_len_count", done_len_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
